// File: rtl/reg_context_engine_if.sv
// Single-beat memory bus between the register context engine (master) and memory (slave).
interface reg_context_engine_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 32
);
    logic             bus_cyc;
    logic             bus_we;
    logic [AW-1:0]    bus_adr;
    logic [WIDTH-1:0] bus_dat_o;
    logic [WIDTH-1:0] bus_dat_i;
    logic             bus_ack;
    logic             bus_err;

    modport master (
        output bus_cyc, bus_we, bus_adr, bus_dat_o,
        input  bus_dat_i, bus_ack, bus_err
    );

    modport slave (
        input  bus_cyc, bus_we, bus_adr, bus_dat_o,
        output bus_dat_i, bus_ack, bus_err
    );
endinterface

// File: rtl/reg_context_engine.sv
// Saves masked registers to memory on exception entry and restores them on return.
// Optional ack watchdog enabled by defining CTXENG_TIMEOUT_EN.
module reg_context_engine #(
    parameter int WIDTH   = 64,
    parameter int COUNT   = 16,
    parameter int COUNTP  = 4,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_save,
    input  logic                 start_restore,
    input  logic [AW-1:0]        base_addr,
    input  logic [COUNT-1:0]     reg_mask,
    output logic [COUNTP-1:0]    rf_read_addr,
    input  logic [WIDTH-1:0]     rf_data,
    output logic [COUNTP-1:0]    rf_write_addr,
    output logic [WIDTH-1:0]     rf_write_data,
    output logic                 rf_write_en,
    reg_context_engine_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    typedef enum logic [2:0] {IDLE, SCAN, LOAD, XFER, FIN} state_t;

    localparam logic [AW-1:0]     STEP = AW'(WIDTH / 8);
    localparam logic [COUNTP-1:0] LAST = COUNTP'(COUNT - 1);

    state_t             state_q;
    logic [COUNTP-1:0]  idx_q, idx_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [COUNT-1:0]   mask_q;
    logic [WIDTH-1:0]   dat_q;
    logic               save_q;
    logic               err_q;
    logic               tmo_hit;
    logic               in_xfer;

    assign idx_d   = idx_q + 1'b1;
    assign addr_d  = addr_q + STEP;
    assign in_xfer = (state_q == XFER);

`ifdef CTXENG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    // Counts XFER cycles; reads zero on the first cycle of every transfer.
    always_ff @(posedge clk) begin
        if (rst || !in_xfer) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            save_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_save || start_restore) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                        mask_q  <= reg_mask;
                        save_q  <= start_save;
                        addr_q  <= base_addr;
                    end
                end
                SCAN: begin
                    if (mask_q[idx_q]) begin
                        state_q <= save_q ? LOAD : XFER;
                    end else if (idx_q == LAST) begin
                        state_q <= FIN;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                LOAD: begin
                    dat_q   <= rf_data;
                    state_q <= XFER;
                end
                XFER: begin
                    // An error beats a coincident ack; a real response beats the watchdog.
                    if (bus.bus_err) begin
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end else if (bus.bus_ack) begin
                        addr_q <= addr_d;
                        if (idx_q == LAST) begin
                            state_q <= FIN;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= SCAN;
                        end
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);
    assign error         = done && err_q;
    assign rf_read_addr  = idx_q;
    assign rf_write_addr = idx_q;
    assign rf_write_en   = in_xfer && !save_q && bus.bus_ack && !bus.bus_err;
    assign rf_write_data = rf_write_en ? bus.bus_dat_i : '0;

    assign bus.bus_cyc   = in_xfer;
    assign bus.bus_we    = in_xfer && save_q;
    assign bus.bus_adr   = in_xfer ? addr_q : '0;
    assign bus.bus_dat_o = (in_xfer && save_q) ? dat_q : '0;
endmodule
